// File: rtl/usb_uart_fifo_bridge.sv
// Byte-wide client bridge between a uart_we/uart_re handshake and USB CDC bulk endpoints.
// Two FIFOs (TX toward IN, RX from OUT) plus an idle-timeout short-packet flush.
module usb_uart_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned FLUSH_CYCLES = 48000
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic                  uart_we,
  input  logic                  uart_re,
  input  logic [7:0]            uart_di,
  output logic [7:0]            uart_do,
  output logic                  uart_wait,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_flush,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DEPTH_LOG2:0]   tx_level,
  output logic [DEPTH_LOG2:0]   rx_level
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned PW       = DEPTH_LOG2 + 1;
  localparam int unsigned AW       = DEPTH_LOG2;
  localparam int unsigned CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  logic [PW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [7:0]    r_uart_do;
  logic [CW-1:0] r_cnt;
  state_t        r_state, w_next;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_wait, w_wr_acc, w_rd_acc, w_tx_pop, w_rx_push;
  logic w_cnt_clr, w_cnt_inc, w_flush, w_cnt_last;

  // Status from registered pointers only, so same-cycle traffic never unblocks
  assign w_tx_full  = (r_tx_wptr[PW-1] != r_tx_rptr[PW-1]) &&
                      (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_rx_full  = (r_rx_wptr[PW-1] != r_rx_rptr[PW-1]) &&
                      (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);

  // One shared wait makes simultaneous write+read all-or-nothing
  assign w_wait    = (uart_we & w_tx_full) | (uart_re & w_rx_empty);
  assign w_wr_acc  = uart_we & ~w_wait;
  assign w_rd_acc  = uart_re & ~w_wait;
  assign w_tx_pop  = ~w_tx_empty & tx_ready;
  assign w_rx_push = rx_valid & ~w_rx_full;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_uart_do <= '0;
    end else begin
      if (w_wr_acc)  r_tx_wptr <= r_tx_wptr + PW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PW'(1);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PW'(1);
      if (w_rd_acc) begin
        r_rx_rptr <= r_rx_rptr + PW'(1);
        r_uart_do <= r_rx_mem[r_rx_rptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge clk_48mhz) begin
    if (w_wr_acc)  r_tx_mem[r_tx_wptr[AW-1:0]] <= uart_di;
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= rx_data;
  end

  assign w_cnt_last = (r_cnt == CW'(CNT_LAST));

  always_ff @(posedge clk_48mhz) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_tx_pop) w_next = ST_ARMED;
      ST_ARMED: if (!w_tx_pop && !w_wr_acc && w_tx_empty && w_cnt_last) w_next = ST_FLUSH;
      ST_FLUSH: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_flush   = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_IDLE:  w_cnt_clr = w_tx_pop;
      ST_ARMED: begin
        w_cnt_clr = w_tx_pop | w_wr_acc;
        w_cnt_inc = ~w_cnt_clr & w_tx_empty & ~w_cnt_last;
      end
      ST_FLUSH: w_flush = 1'b1;
      default:  w_flush = 1'b0;
    endcase
  end

  // Idle counter saturates at the threshold instead of wrapping
  always_ff @(posedge clk_48mhz) begin
    if (reset)          r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
  end

  assign uart_do   = r_uart_do;
  assign uart_wait = w_wait;
  assign tx_data   = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign tx_valid  = ~w_tx_empty;
  assign tx_flush  = w_flush;
  assign rx_ready  = ~w_rx_full;
  assign tx_level  = r_tx_wptr - r_tx_rptr;
  assign rx_level  = r_rx_wptr - r_rx_rptr;

endmodule

// File: tb/tb_usb_uart_fifo_bridge.sv
// Bench for usb_uart_fifo_bridge: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic phases.
module tb_usb_uart_fifo_bridge;

  localparam int FC = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_we, uart_re;
  logic [7:0] uart_di, uart_do;
  logic       uart_wait;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_flush;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [4:0] tx_level, rx_level;

  usb_uart_fifo_bridge #(.DEPTH_LOG2(4), .FLUSH_CYCLES(FC)) dut (
    .clk_48mhz(clk), .reset(reset),
    .uart_we(uart_we), .uart_re(uart_re), .uart_di(uart_di), .uart_do(uart_do),
    .uart_wait(uart_wait),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queues plus "quiet cycles since last TX activity"
  byte unsigned txq[$];
  byte unsigned rxq[$];
  logic [7:0]   m_do;
  bit           m_armed, m_flush, en;
  int           m_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function bit m_wait();
    return (uart_we && txq.size() == DEPTH) || (uart_re && rxq.size() == 0);
  endfunction

  // Advance one clock edge, updating the model from the inputs the DUT sampled
  task automatic cycle();
    bit w, pop, rp, wr, rd, e;
    @(posedge clk);
    if (reset) begin
      txq.delete(); rxq.delete();
      m_do = 8'h00; m_armed = 0; m_flush = 0; m_idle = 0; en = 1;
    end else begin
      w   = m_wait();
      e   = (txq.size() == 0);
      pop = !e && tx_ready;
      rp  = rx_valid && rxq.size() < DEPTH;
      wr  = uart_we && !w;
      rd  = uart_re && !w;
      if (m_flush) m_flush = 0;
      else if (!m_armed) begin
        if (pop) begin m_armed = 1; m_idle = 0; end
      end else if (pop || wr) m_idle = 0;
      else if (e) begin
        if (m_idle == FC - 1) begin m_flush = 1; m_armed = 0; end
        else m_idle++;
      end
      if (pop) void'(txq.pop_front());
      if (wr)  txq.push_back(uart_di);
      if (rd)  m_do = rxq.pop_front();
      if (rp)  rxq.push_back(rx_data);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (en) begin
      chk("uart_wait", uart_wait, m_wait());
      chk("tx_valid", tx_valid, txq.size() != 0);
      if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
      chk("tx_level", tx_level, txq.size());
      chk("rx_level", rx_level, rxq.size());
      chk("rx_ready", rx_ready, rxq.size() != DEPTH);
      chk("uart_do", uart_do, m_do);
      chk("tx_flush", tx_flush, m_flush);
    end
  end

  task automatic idle_inputs();
    uart_we = 0; uart_re = 0; tx_ready = 0; rx_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; cycle(); reset = 0;
  endtask

  function automatic bit pr(input int num);
    return $urandom_range(0, 15) < num;
  endfunction

  initial begin
    en = 0;
    reset = 1; uart_di = 0; rx_data = 0;
    idle_inputs();
    cycle(); cycle(); reset = 0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_uart_do", uart_do, 0);
    chk("rst_tx_flush", tx_flush, 0);
    chk("rst_tx_level", tx_level, 0);

    // Three writes with the IN endpoint stalled
    for (int i = 0; i < 3; i++) begin
      uart_we = 1; uart_di = 8'h41 + 8'(i); #1;
      chk("w3_wait", uart_wait, 0);
      cycle();
    end
    uart_we = 0;
    chk("w3_level", tx_level, 3);
    chk("w3_valid", tx_valid, 1);
    chk("w3_data", tx_data, 8'h41);

    // Fill, then a write racing a same-cycle pop stays blocked
    for (int i = 0; i < 13; i++) begin
      uart_we = 1; uart_di = 8'h44 + 8'(i); cycle();
    end
    chk("fill_level", tx_level, 16);
    uart_we = 1; uart_di = 8'hA0; tx_ready = 1; #1;
    chk("w17_wait", uart_wait, 1);
    cycle();
    chk("w17_level_pop", tx_level, 15);
    tx_ready = 0; #1;
    chk("w17_wait_next", uart_wait, 0);
    cycle();
    uart_we = 0;
    chk("w17_level", tx_level, 16);
    chk("w17_head", tx_data, 8'h42);

    // RX push then client reads
    rx_valid = 1; rx_data = 8'h55; cycle(); rx_valid = 0;
    uart_re = 1; #1;
    chk("rd_wait", uart_wait, 0);
    cycle();
    chk("rd_do", uart_do, 8'h55);
    chk("rd_level", rx_level, 0);
    #1;
    chk("rd2_wait", uart_wait, 1);
    cycle(); uart_re = 0;
    chk("rd2_do_hold", uart_do, 8'h55);

    // Atomic write+read blocked by full TX, then both accepted after one drain
    rx_valid = 1; rx_data = 8'h66; cycle(); rx_valid = 0;
    uart_we = 1; uart_re = 1; uart_di = 8'hB0; #1;
    chk("atom_wait", uart_wait, 1);
    cycle();
    chk("atom_tx_level", tx_level, 16);
    chk("atom_rx_level", rx_level, 1);
    tx_ready = 1; cycle(); tx_ready = 0;
    chk("atom_drain", tx_level, 15);
    #1;
    chk("atom_wait_clear", uart_wait, 0);
    cycle();
    uart_we = 0; uart_re = 0;
    chk("atom_tx_after", tx_level, 16);
    chk("atom_rx_after", rx_level, 0);
    chk("atom_do", uart_do, 8'h66);

    // Idle-timeout flush after a short burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      uart_we = 1; uart_di = 8'(i + 1); cycle();
    end
    uart_we = 0; tx_ready = 1;
    repeat (5) cycle();
    tx_ready = 0;
    chk("fl_drained", tx_level, 0);
    for (int k = 1; k <= 40; k++) begin
      cycle();
      chk($sformatf("fl_pulse_%0d", k), tx_flush, k == FC);
    end

    // Reset with both FIFOs holding 7 bytes
    do_reset();
    for (int i = 0; i < 8; i++) begin
      uart_we = (i < 7); uart_di = 8'(i); rx_valid = 1; rx_data = 8'h10 + 8'(i); cycle();
    end
    uart_we = 0; rx_valid = 0;
    uart_re = 1; cycle(); uart_re = 0;
    chk("pre_rst_tx", tx_level, 7);
    chk("pre_rst_rx", rx_level, 7);
    chk("pre_rst_do", uart_do, 8'h10);
    reset = 1; cycle(); reset = 0;
    chk("mid_rst_tx", tx_level, 0);
    chk("mid_rst_rx", rx_level, 0);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_ready", rx_ready, 1);
    chk("mid_rst_do", uart_do, 0);

    // Randomized phases: fill-heavy, drain-heavy, mixed, quiet (flush-prone)
    for (int ph = 0; ph < 12; ph++) begin
      for (int c = 0; c < 300; c++) begin
        case (ph % 4)
          0: begin uart_we = pr(12); tx_ready = pr(2);  rx_valid = pr(12); uart_re = pr(2);  end
          1: begin uart_we = pr(2);  tx_ready = pr(12); rx_valid = pr(2);  uart_re = pr(12); end
          2: begin uart_we = pr(8);  tx_ready = pr(8);  rx_valid = pr(8);  uart_re = pr(8);  end
          default: begin uart_we = ($urandom_range(0, 31) == 0); tx_ready = pr(8);
                         rx_valid = 0; uart_re = 0; end
        endcase
        uart_di = 8'($urandom);
        rx_data = 8'($urandom);
        reset   = ($urandom_range(0, 599) == 0);
        cycle();
      end
    end
    reset = 0;
    idle_inputs();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
